// File: rtl/clock_display_scanner.sv
// clock_display_scanner: scans the six BCD clock digits onto a common-anode 7-segment display
// with frame snapshot, leading-zero blanking, colon dots and set-mode blink. Option: SCAN_GHOST_GUARD_EN.
module clock_display_scanner #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLINK_FRAMES = 64,
   parameter int GUARD_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] currentBits,
   input  logic [3:0]  state,
   output logic [5:0]  anode,
   output logic [6:0]  segments,
   output logic        dp
);
   localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   localparam logic [DW-1:0] DIV_LAST   = DW'(REFRESH_DIV - 1);
   localparam logic [DW-1:0] GUARD_LIM  = DW'(GUARD_CYCLES);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
   localparam logic [3:0]    STATE_SET  = 4'd1;
`ifdef SCAN_GHOST_GUARD_EN
   localparam logic GUARD_ON = 1'b1;
`else
   localparam logic GUARD_ON = 1'b0;
`endif

   logic [DW-1:0] divCnt;
   logic [2:0]    digitIdx;
   logic [FW-1:0] frameCnt;
   logic          blinkPhase;
   logic [23:0]   snapshot;

   logic [DW-1:0] divNext;
   logic [2:0]    idxNext;
   logic [FW-1:0] frameNext;
   logic          blinkNext;
   logic [23:0]   snapNext;
   logic          slotEnd;
   logic          frameEnd;
   logic [3:0]    digitNext;
   logic          blankNext;
   logic [5:0]    anodeNext;
   logic [6:0]    segNext;
   logic          dpNext;

   function automatic logic [6:0] decode7(input logic [3:0] d);
      case (d)
         4'd0:    decode7 = 7'b1000000;
         4'd1:    decode7 = 7'b1111001;
         4'd2:    decode7 = 7'b0100100;
         4'd3:    decode7 = 7'b0110000;
         4'd4:    decode7 = 7'b0011001;
         4'd5:    decode7 = 7'b0010010;
         4'd6:    decode7 = 7'b0000010;
         4'd7:    decode7 = 7'b1111000;
         4'd8:    decode7 = 7'b0000000;
         4'd9:    decode7 = 7'b0010000;
         default: decode7 = 7'b0111111;
      endcase
   endfunction

   // Next-state values; outputs are decoded from these so they change on the same edge as digitIdx
   always_comb begin
      slotEnd  = (divCnt == DIV_LAST);
      frameEnd = slotEnd && (digitIdx == 3'd5);

      if (slotEnd) begin
         divNext = '0;
         idxNext = frameEnd ? 3'd0 : digitIdx + 3'd1;
      end else begin
         divNext = divCnt + DW'(1);
         idxNext = digitIdx;
      end

      snapNext = frameEnd ? currentBits : snapshot;

      if (state != STATE_SET) begin
         frameNext = '0;
         blinkNext = 1'b0;
      end else if (frameEnd) begin
         if (frameCnt == FRAME_LAST) begin
            frameNext = '0;
            blinkNext = ~blinkPhase;
         end else begin
            frameNext = frameCnt + FW'(1);
            blinkNext = blinkPhase;
         end
      end else begin
         frameNext = frameCnt;
         blinkNext = blinkPhase;
      end

      case (idxNext)
         3'd0:    digitNext = snapNext[3:0];
         3'd1:    digitNext = snapNext[7:4];
         3'd2:    digitNext = snapNext[11:8];
         3'd3:    digitNext = snapNext[15:12];
         3'd4:    digitNext = snapNext[19:16];
         3'd5:    digitNext = snapNext[23:20];
         default: digitNext = 4'd0;
      endcase

      // Guard term folds to zero when the option is compiled out
      blankNext = (GUARD_ON && (divNext < GUARD_LIM))
               || ((state == STATE_SET) && blinkNext)
               || ((idxNext == 3'd5) && (snapNext[23:20] == 4'd0));

      if (blankNext) begin
         anodeNext = 6'b111111;
      end else begin
         anodeNext = ~(6'b000001 << idxNext);
      end

      segNext = decode7(digitNext);
      dpNext  = ~((idxNext == 3'd2) || (idxNext == 3'd4));
   end

   // Scan state and registered display outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         divCnt     <= '0;
         digitIdx   <= 3'd0;
         frameCnt   <= '0;
         blinkPhase <= 1'b0;
         snapshot   <= 24'd0;
         anode      <= 6'b111111;
         segments   <= 7'b1111111;
         dp         <= 1'b1;
      end else begin
         divCnt     <= divNext;
         digitIdx   <= idxNext;
         frameCnt   <= frameNext;
         blinkPhase <= blinkNext;
         snapshot   <= snapNext;
         anode      <= anodeNext;
         segments   <= segNext;
         dp         <= dpNext;
      end
   end
endmodule
